// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
//   Generates sequential word-aligned fetch addresses, issues them to
//   instruction memory (imem_req/imem_ready handshake, in-order imem_rvalid
//   responses), buffers returned words in a small circular FIFO and presents
//   one instruction per cycle to decode.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   stall               decode not accepting; output registers hold
//   redirect/redirect_pc  kill everything, restart fetch at redirect_pc
//   imem_req/imem_addr  fetch request and its word address
//   imem_ready          memory accepts the request this cycle
//   imem_rvalid/imem_rdata  in-order response word
//   instruction0/inst0_pc/inst0_valid  instruction presented to decode
//
// Credit scheme: requests in flight plus words buffered never exceed DEPTH,
// so every response always has a FIFO slot and the FIFO cannot overflow.
// On redirect every request still in flight is counted into drop_cnt and
// its response is discarded when it comes back.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction0,
  output logic [31:0] inst0_pc,
  output logic        inst0_valid
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  // fetch / response address tracking
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   target_pc;

  // credit bookkeeping
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;

  // FIFO storage
  fetch_entry_t  fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // per-cycle events
  logic          hs;
  logic          rsp;
  logic          push;
  logic          pop;

  assign target_pc   = {redirect_pc[31:2], 2'b00};
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};

  // Registered counts only: a credit freed this cycle is reusable next cycle.
  // The reset term keeps the request low for as long as reset is held.
  assign imem_req  = reset && !redirect && (credit_used < CREDITS);
  assign imem_addr = fetch_pc;

  assign hs   = imem_req && imem_ready;
  // A response with nothing outstanding is illegal; ignoring it keeps the
  // counters from wrapping.
  assign rsp  = imem_rvalid && (outstanding != '0);
  assign push = rsp && !redirect && (drop_cnt == '0);
  assign pop  = !redirect && !stall && (fifo_count != '0);

  //--------------------------------------------------------------------------
  // fetch side
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= target_pc;
    end else if (hs) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding <= '0;
    end else begin
      outstanding <= outstanding + CW'(hs) - CW'(rsp);
    end
  end

  //--------------------------------------------------------------------------
  // response side
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_pc <= RESET_PC;
    end else if (redirect) begin
      resp_pc <= target_pc;
    end else if (push) begin
      resp_pc <= resp_pc + 32'd4;
    end
  end

  // Everything in flight at redirect time is stale, except a response that
  // lands in the redirect cycle itself: that one is discarded right away.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (redirect) begin
      drop_cnt <= outstanding - CW'(rsp);
    end else if (rsp && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - CW'(1);
    end
  end

  //--------------------------------------------------------------------------
  // instruction FIFO (registered, no bypass: a push is visible next cycle)
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{inst: imem_rdata, pc: resp_pc};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (redirect) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  //--------------------------------------------------------------------------
  // output stage
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instruction0 <= NOP_INST;
      inst0_pc     <= 32'h0;
      inst0_valid  <= 1'b0;
    end else if (redirect) begin
      instruction0 <= NOP_INST;
      inst0_valid  <= 1'b0;
    end else if (!stall) begin
      if (pop) begin
        instruction0 <= fifo_mem[rd_ptr].inst;
        inst0_pc     <= fifo_mem[rd_ptr].pc;
        inst0_valid  <= 1'b1;
      end else begin
        instruction0 <= NOP_INST;
        inst0_valid  <= 1'b0;
      end
    end
  end

  //--------------------------------------------------------------------------
  // simulation checks
  //--------------------------------------------------------------------------
  a_rvalid_legal: assert property (@(posedge clk) disable iff (!reset)
    !(imem_rvalid && (outstanding == '0)));

  a_credit_bound: assert property (@(posedge clk) disable iff (!reset)
    credit_used <= CREDITS);

  a_drop_bound: assert property (@(posedge clk) disable iff (!reset)
    drop_cnt <= outstanding);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] WPC0  = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0, redirect = 1'b0, imem_ready = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] redirect_pc = '0, imem_rdata = '0;
  logic        imem_req, inst0_valid;
  logic [31:0] imem_addr, instruction0, inst0_pc;

  // second instance: wrap-around start address, free-running 1-cycle memory
  logic        stall_w = 1'b0, redirect_w = 1'b0, ready_w = 1'b1, rvalid_w = 1'b0;
  logic [31:0] redirect_pc_w = '0, rdata_w = '0;
  logic        req_w, valid_w;
  logic [31:0] addr_w, inst_w, pc_w;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction0(instruction0), .inst0_pc(inst0_pc), .inst0_valid(inst0_valid));

  fetch_unit #(.RESET_PC(WPC0), .DEPTH(DEPTH), .NOP_INST(NOP)) dut_w (
    .clk(clk), .reset(reset), .stall(stall_w), .redirect(redirect_w),
    .redirect_pc(redirect_pc_w), .imem_req(req_w), .imem_addr(addr_w),
    .imem_ready(ready_w), .imem_rvalid(rvalid_w), .imem_rdata(rdata_w),
    .instruction0(inst_w), .inst0_pc(pc_w), .inst0_valid(valid_w));

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- memory model ----------------
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mem_q[$];
  int    cyc = 0;
  int    lat = 1;

  // ---------------- reference model ----------------
  // Transaction view: a queue of in-flight requests (each tagged stale or
  // not) and a queue of buffered {inst,pc}; credits = total queue occupancy.
  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
  ent_t        m_fifo[$];
  bit          m_infl[$];
  logic [31:0] m_fetch_pc, m_resp_pc, m_inst, m_pc;
  bit          m_valid;

  // wrap instance tracking
  bit          w_last_hs;
  logic [31:0] w_last_addr, w_exp_addr, w_exp_pc;

  function automatic bit model_req(bit r);
    return !r && (m_infl.size() + m_fifo.size() < DEPTH);
  endfunction

  function automatic void model_edge(bit s, bit r, logic [31:0] rp, bit rdy,
                                     bit rv, logic [31:0] rd);
    bit   hs;
    bit   stale;
    ent_t e;
    hs = model_req(r) && rdy;
    if (r) begin
      m_inst = NOP; m_valid = 1'b0;
    end else if (!s) begin
      if (m_fifo.size() > 0) begin
        e = m_fifo.pop_front();
        m_inst = e.inst; m_pc = e.pc; m_valid = 1'b1;
      end else begin
        m_inst = NOP; m_valid = 1'b0;
      end
    end
    if (rv && m_infl.size() > 0) begin
      stale = m_infl.pop_front();
      if (!r && !stale) begin
        m_fifo.push_back('{rd, m_resp_pc});
        m_resp_pc = m_resp_pc + 32'd4;
      end
    end
    if (r) begin
      m_fifo.delete();
      foreach (m_infl[i]) m_infl[i] = 1'b1;
      m_fetch_pc = {rp[31:2], 2'b00};
      m_resp_pc  = {rp[31:2], 2'b00};
    end else if (hs) begin
      m_infl.push_back(1'b0);
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
  endfunction

  // Reset applied at a negedge (mid-transaction when called during traffic),
  // released just after the following posedge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0; redirect = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
    rvalid_w = 1'b0;
    #1;
    chk("rst_inst", instruction0, NOP);
    chk("rst_pc", inst0_pc, 32'h0);
    chk("rst_valid", inst0_valid, 1'b0);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_req_w", req_w, 1'b0);
    chk("rst_addr_w", addr_w, WPC0);
    mem_q.delete(); m_fifo.delete(); m_infl.delete();
    m_fetch_pc = 32'h0; m_resp_pc = 32'h0;
    m_inst = NOP; m_pc = 32'h0; m_valid = 1'b0;
    w_last_hs = 1'b0; w_last_addr = '0; w_exp_addr = WPC0; w_exp_pc = WPC0;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic cycle(input bit s, input bit r, input logic [31:0] rp, input bit rdy);
    bit mreq;
    @(negedge clk);
    stall = s; redirect = r; redirect_pc = rp; imem_ready = rdy;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h1000_0000 | mem_q[0].addr;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    rvalid_w = w_last_hs;
    rdata_w  = 32'h1000_0000 | w_last_addr;
    #1;
    mreq = model_req(r);
    chk("imem_req", imem_req, mreq);
    chk("imem_addr", imem_addr, m_fetch_pc);
    chk("req_w", req_w, 1'b1);
    chk("addr_w", addr_w, w_exp_addr);
    if (imem_rvalid) void'(mem_q.pop_front());
    if (imem_req && imem_ready) mem_q.push_back('{imem_addr, cyc + lat});
    w_last_hs = req_w;
    w_last_addr = addr_w;
    if (req_w) w_exp_addr = w_exp_addr + 32'd4;
    model_edge(s, r, rp, rdy, imem_rvalid, imem_rdata);
    cyc++;
    @(posedge clk);
    #1;
    chk("inst0_valid", inst0_valid, m_valid);
    chk("instruction0", instruction0, m_inst);
    chk("inst0_pc", inst0_pc, m_pc);
    if (inst0_valid === 1'b1)
      chk("inst_data_assoc", instruction0, 32'h1000_0000 | inst0_pc);
    if (valid_w === 1'b1) begin
      chk("pc_w", pc_w, w_exp_pc);
      chk("inst_w", inst_w, 32'h1000_0000 | pc_w);
      w_exp_pc = w_exp_pc + 32'd4;
    end
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      lat = $urandom_range(1, 4);
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0),
            $urandom, ($urandom_range(0, 9) < 7));
    end
  endtask

  initial begin
    int guard;
    do_reset();

    // steady stream, 1-cycle memory
    lat = 1;
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, '0, 1'b1);
    chk("stream_valid", inst0_valid, 1'b1);

    // stall 5 cycles mid-stream, then resume
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, '0, 1'b1);
    chk("stall_req_drop", imem_req, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, '0, 1'b1);

    // 3-cycle memory, redirect with 3 requests in flight
    lat = 3;
    guard = 0;
    while (m_infl.size() != 3 && guard < 20) begin
      cycle(1'b0, 1'b0, '0, 1'b1);
      guard++;
    end
    chk("reach_3_inflight", m_infl.size(), 3);
    cycle(1'b0, 1'b1, 32'h0000_0203, 1'b1);
    chk("redir_addr", imem_addr, 32'h0000_0200);
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b0, '0, 1'b1);

    // redirect together with stall and a response in the same cycle
    lat = 2;
    guard = 0;
    while (!(mem_q.size() > 1 && mem_q[0].due <= cyc) && guard < 20) begin
      cycle(1'b0, 1'b0, '0, 1'b1);
      guard++;
    end
    chk("rsp_pending", (mem_q.size() > 1 && mem_q[0].due <= cyc), 1'b1);
    cycle(1'b1, 1'b1, 32'h0000_0300, 1'b1);
    chk("rs_valid", inst0_valid, 1'b0);
    chk("rs_inst", instruction0, NOP);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, '0, 1'b1);

    // memory not ready for 4 cycles after a redirect
    cycle(1'b0, 1'b1, 32'h0000_0400, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b0);
    chk("nrdy_addr", imem_addr, 32'h0000_0400);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, '0, 1'b1);

    // redirect near the top of the address space: fetch wraps to 0
    lat = 1;
    cycle(1'b0, 1'b1, 32'hFFFF_FFF9, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, '0, 1'b1);

    // random traffic, reset mid-run, more random traffic
    random_run(400);
    do_reset();
    random_run(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that produces the `instruction0` / `inst0_pc` stream consumed by the decode stage. It has four jobs:
- generate sequential fetch addresses;
- issue requests to instruction memory over a req/ready + rvalid handshake;
- buffer returned words in an in-order FIFO;
- present one instruction per cycle to decode, honouring stall and kill/redirect from the back end.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset.
DEPTH, 4, credit limit: maximum in-flight requests plus buffered instructions (power of 2, >= 2).
NOP_INST, 32'h0000_0013, instruction driven when no valid instruction is presented (addi x0,x0,0).

Ports:
clk  input  1  clock.
reset  input  1  asynchronous, active-low reset.
stall  input  1  downstream stall; output registers hold.
redirect  input  1  kill/redirect: flush all state, restart fetch at redirect_pc.
redirect_pc  input  32  new fetch target; bits [1:0] ignored (forced to 00).
imem_req  output  1  fetch request valid.
imem_addr  output  32  fetch address, word aligned.
imem_ready  input  1  memory accepts the request this cycle (handshake = imem_req && imem_ready).
imem_rvalid  input  1  response word valid; responses return in request order, latency >= 1 cycle.
imem_rdata  input  32  response instruction word.
instruction0  output  32  instruction to decode.
inst0_pc  output  32  PC of instruction0.
inst0_valid  output  1  instruction0 is a real fetched instruction.

Behaviour:
- Reset (async, reset==0) values:
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - outstanding=0, drop_cnt=0, FIFO empty.
  - instruction0=NOP_INST, inst0_pc=32'h0, inst0_valid=0.
  - imem_req=0 while reset is asserted.
- Reset asserted mid-transaction: everything returns to reset values immediately. The memory side must also be reset; stale responses after reset are not tracked.
- Counter widths: outstanding, drop_cnt and fifo_count are each $clog2(DEPTH+1) bits.
- imem_addr = fetch_pc at all times.
- Request issue: imem_req = !redirect && (outstanding + fifo_count < DEPTH). Uses registered counts only; there is no same-cycle credit return.
- On handshake: fetch_pc += 4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0); outstanding++.
- Response (imem_rvalid):
  - outstanding-- always.
  - If drop_cnt != 0: drop_cnt--, word discarded.
  - Else: push {imem_rdata, resp_pc} into the FIFO and set resp_pc += 4.
- Simultaneous handshake and response: outstanding is unchanged net.
- Output stage, when !stall && !redirect:
  - FIFO non-empty: pop the head into instruction0/inst0_pc; inst0_valid=1.
  - FIFO empty: instruction0=NOP_INST, inst0_valid=0, inst0_pc unchanged.
- Output stage, when stall && !redirect: all outputs hold; no pop. Push and issue continue subject to credit.
- Simultaneous push and pop on the same cycle is allowed; fifo_count is unchanged. FIFO is circular, pointers wrap at DEPTH.
- Redirect (highest priority, overrides stall), taking effect next edge:
  - fetch_pc <= resp_pc <= {redirect_pc[31:2],2'b00}.
  - FIFO flushed (pointers and count zeroed).
  - instruction0 <= NOP_INST, inst0_valid <= 0, inst0_pc unchanged.
  - drop_cnt <= outstanding - imem_rvalid (every request still in flight becomes stale).
  - imem_req=0 during the redirect cycle.
  - A response arriving in the redirect cycle is discarded.
- Back-to-back redirects: the latest target wins; drop_cnt is recomputed each time from outstanding.
- Invariant: outstanding + fifo_count <= DEPTH; drop_cnt <= outstanding.
- Illegal: imem_rvalid with outstanding==0. Simulation assertion error; the counter does not underflow.
- Latency: a word returned at cycle N with an empty FIFO and no stall appears on instruction0 at edge N+1.
- Throughput: with 1-cycle memory latency and no stall, one instruction per cycle is sustained.

Test Plan:
- Reset release, memory with 1-cycle latency returning word (0x1000_0000|addr), no stall → addresses 0,4,8,… issued every cycle; inst0_pc 0,4,8 with inst0_valid=1 each cycle after a 2-cycle fill.
- stall held high 5 cycles mid-stream → instruction0/inst0_pc frozen; imem_req drops once outstanding+fifo_count=4; after release, stream resumes at the next PC with no gap or duplicate.
- Memory latency 3, redirect to 0x0000_0203 while 3 requests are in flight → next issued address 0x200; 3 stale responses dropped; first valid output has inst0_pc=0x200; no stale PC ever appears with inst0_valid=1.
- Redirect asserted together with stall and imem_rvalid → output goes to NOP_INST/valid=0 on the next edge; the simultaneous response is dropped; drop_cnt = outstanding-1.
- Start at RESET_PC=32'hFFFF_FFF8 → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; inst0_pc wraps correctly.
- imem_ready low for 4 cycles → imem_req/imem_addr held stable; fetch_pc not advanced; after that inst0_valid=0 with NOP_INST presented until data arrives.
